ex_cond_stage: RTL and testbench
================================

# ex_cond_stage

Execute-to-memory stage that sits directly downstream of the 32-bit ALU. It captures the ALU result and its {neg, zero, carry, overflow} flags into the EX/MEM pipeline register. It holds the architectural status-flag register and evaluates each instruction's 4-bit condition code against the committed flags, turning failed-condition instructions into bubbles. It also keeps executed/squashed performance counters.

## Interface
- N, 32, datapath width (matches ALU)
- RA, 4, destination register address width
- CW, 32, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  ALU output holds a real instruction this cycle
- stall  in  1  freeze the stage (downstream not ready)
- flush  in  1  kill the instruction presented this cycle
- alu_result  in  N  ALU result
- alu_flags  in  4  [3]=neg, [2]=zero, [1]=carry, [0]=overflow
- set_flags  in  1  instruction updates the status register
- cond  in  4  condition code
- rd  in  RA  destination register
- reg_write  in  1  instruction writes rd
- out_valid  out  1  EX/MEM register holds an executed instruction
- out_result  out  N  registered result
- out_rd  out  RA  registered destination
- out_reg_write  out  1  registered write enable
- flags_q  out  4  committed status flags, same bit order as alu_flags
- cond_pass  out  1  combinational: cond is true against flags_q
- exec_cnt  out  CW  instructions executed
- squash_cnt  out  CW  instructions squashed by failed condition

## Operation
- Condition table, using flags_q with n,z,c,v:
  - 0000 EQ z; 0001 NE !z; 0010 CS c; 0011 CC !c
  - 0100 MI n; 0101 PL !n; 0110 VS v; 0111 VC !v
  - 1000 HI c&!z; 1001 LS !c|z; 1010 GE n==v; 1011 LT n!=v
  - 1100 GT !z&(n==v); 1101 LE z|(n!=v); 1110 AL 1; 1111 NV 0
- Condition always uses flags_q, i.e. the flags before the current instruction. An instruction never sees its own flags.
- accept = in_valid & !stall & !flush.
- exec = accept & cond_pass. squash = accept & !cond_pass.
- On exec:
  - out_result, out_rd and out_reg_write load from the inputs; out_valid becomes 1.
  - If set_flags, flags_q loads alu_flags.
  - exec_cnt increments.
- On squash:
  - out_valid = 0 and out_reg_write = 0. out_result and out_rd are don't-care (they hold their value).
  - flags_q is unchanged and squash_cnt increments.
- On flush with stall low: the bubble is loaded (out_valid = 0, out_reg_write = 0). Flags and counters are unchanged.
- On !in_valid with stall low: same as flush.
- On stall and no flush: every register holds, including outputs, flags and counters.
- On flush together with stall: flush wins. The output becomes a bubble and flags and counters are unchanged.
- Counters wrap modulo 2^CW with no saturation.
- Flag update is gated only by exec & set_flags. Garbage alu_flags on invalid cycles never reaches flags_q.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k appears on the out_* ports after edge k.
- Back-to-back compare then branch needs no bypass. Flags written at edge k are visible to cond_pass for the instruction presented in cycle k+1.
- cond_pass is purely combinational from cond and flags_q. It is independent of in_valid, stall and flush.
- While rst_n is low, regardless of clk:
  - out_valid = 0, out_reg_write = 0, out_result = 0, out_rd = 0
  - flags_q = 4'b0000, exec_cnt = 0, squash_cnt = 0
- Reset asserted mid-stream drops the in-flight instruction with no partial flag update.
- The first rising edge after rst_n deasserts may accept an instruction.

## Test plan
- Reset, then 10+256 with AL, set_flags=1, reg_write=1, rd=3 -> next cycle: out_valid=1, out_result=266, out_rd=3, flags_q=0000, exec_cnt=1.
- 10-10 with set_flags=1 (flags 0110), then EQ in the following cycle -> flags_q=0110, cond_pass=1, second instruction executes, exec_cnt=2.
- 1-10 with set_flags=1 (flags 1000, result 0xFFFFFFF7), then GE -> cond_pass=0, out_valid=0, flags_q stays 1000, squash_cnt=1. A following LT executes.
- Hold stall=1 for 3 cycles with valid inputs -> outputs, flags_q and counters frozen. Then assert flush and stall together -> out_valid=0, counters unchanged.
- 24+(-10) with set_flags=0 after flags=0110 -> out_result=14, flags_q stays 0110. NV condition -> always squashed.
- Assert rst_n low mid-stream with out_valid=1 and flags_q=1000 -> all outputs and counters go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ex_cond_stage.sv
// EX/MEM pipeline register with condition-code evaluation, status-flag register
// and executed/squashed instruction counters.
module ex_cond_stage #(
  parameter int unsigned N  = 32,
  parameter int unsigned RA = 4,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic [N-1:0]  alu_result,
  input  logic [3:0]    alu_flags,
  input  logic          set_flags,
  input  logic [3:0]    cond,
  input  logic [RA-1:0] rd,
  input  logic          reg_write,
  output logic          out_valid,
  output logic [N-1:0]  out_result,
  output logic [RA-1:0] out_rd,
  output logic          out_reg_write,
  output logic [3:0]    flags_q,
  output logic          cond_pass,
  output logic [CW-1:0] exec_cnt,
  output logic [CW-1:0] squash_cnt
);

  logic fn, fz, fc, fv;
  logic accept, exec, squash;

  assign {fn, fz, fc, fv} = flags_q;

  // Condition is judged against committed flags only, never this instruction's own.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond)
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = !fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = !fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = !fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = !fv;
      4'b1000: cond_pass = fc && !fz;
      4'b1001: cond_pass = !fc || fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = !fz && (fn == fv);
      4'b1101: cond_pass = fz || (fn != fv);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  assign accept = in_valid && !stall && !flush;
  assign exec   = accept && cond_pass;
  assign squash = accept && !cond_pass;

  // Flush beats stall; otherwise stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      flags_q       <= 4'b0000;
      exec_cnt      <= '0;
      squash_cnt    <= '0;
    end else if (flush || !stall) begin
      if (exec) begin
        out_valid     <= 1'b1;
        out_result    <= alu_result;
        out_rd        <= rd;
        out_reg_write <= reg_write;
        exec_cnt      <= exec_cnt + CW'(1);
        if (set_flags) flags_q <= alu_flags;
      end else begin
        out_valid     <= 1'b0;
        out_reg_write <= 1'b0;
        if (squash) squash_cnt <= squash_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_cond_stage.sv
// Randomized and directed bench for ex_cond_stage against a behavioural model.
module tb_ex_cond_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush, set_flags, reg_write;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags, cond, rd;
  logic        out_valid, out_reg_write, cond_pass;
  logic [31:0] out_result, exec_cnt, squash_cnt;
  logic [3:0]  out_rd, flags_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid, m_we;
  logic [31:0] m_result;
  logic [3:0]  m_rd, m_flags;
  int unsigned m_exec, m_squash;

  ex_cond_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .alu_flags(alu_flags), .set_flags(set_flags),
    .cond(cond), .rd(rd), .reg_write(reg_write), .out_valid(out_valid),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .flags_q(flags_q), .cond_pass(cond_pass), .exec_cnt(exec_cnt),
    .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition truth from the architectural table, using signed-compare meaning.
  function automatic bit cond_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, ge;
    {n, z, cy, v} = f;
    ge = (n == v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return ge;
      4'd11: return !ge;
      4'd12: return ge && !z;
      4'd13: return !(ge && !z);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 32-bit add/sub returning {result, n z c v}; carry is "no borrow" on subtract.
  function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b, input bit sub);
    longint sa, sb, sr;
    logic [32:0] u;
    logic [31:0] r;
    bit n, z, c, v;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    sr = sub ? sa - sb : sa + sb;
    if (sub) begin
      r = a - b;
      c = (a >= b);
    end else begin
      u = {1'b0, a} + {1'b0, b};
      r = u[31:0];
      c = u[32];
    end
    n = r[31];
    z = (r == 32'd0);
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {r, n, z, c, v};
  endfunction

  task automatic drive(input bit iv, input bit st, input bit fl, input logic [35:0] rf,
                       input bit sf, input logic [3:0] c, input logic [3:0] r, input bit we);
    in_valid = iv; stall = st; flush = fl;
    alu_result = rf[35:4]; alu_flags = rf[3:0];
    set_flags = sf; cond = c; rd = r; reg_write = we;
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_result = '0; m_rd = '0; m_flags = '0; m_exec = 0; m_squash = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".we"}, 64'(out_reg_write), 64'(m_we));
    check({tag, ".flags"}, 64'(flags_q), 64'(m_flags));
    check({tag, ".exec"}, 64'(exec_cnt), 64'(m_exec));
    check({tag, ".squash"}, 64'(squash_cnt), 64'(m_squash));
    if (m_valid) begin
      check({tag, ".result"}, 64'(out_result), 64'(m_result));
      check({tag, ".rd"}, 64'(out_rd), 64'(m_rd));
    end
  endtask

  // One clock: check cond_pass before the edge, advance the model, check registers after.
  task automatic cycle(input string tag);
    bit pass, acc;
    #1;
    pass = cond_eval(cond, m_flags);
    check({tag, ".cond_pass"}, 64'(cond_pass), 64'(pass));
    @(posedge clk);
    acc = in_valid && !stall && !flush;
    if (flush || !stall) begin
      if (acc && pass) begin
        m_valid = 1; m_we = reg_write; m_result = alu_result; m_rd = rd;
        if (set_flags) m_flags = alu_flags;
        m_exec++;
      end else begin
        m_valid = 0; m_we = 0;
        if (acc) m_squash++;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  localparam logic [3:0] EQ = 4'd0, GE = 4'd10, LT = 4'd11, AL = 4'd14, NV = 4'd15;

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1, 0, 0, 36'h0, 1, AL, 4'd1, 1);
    alu_flags = 4'hF;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 10 + 256
    drive(1, 0, 0, alu(32'd10, 32'd256, 0), 1, AL, 4'd3, 1);
    cycle("add");
    check("add.result_const", 64'(out_result), 64'd266);
    check("add.flags_const", 64'(flags_q), 64'h0);

    // 10 - 10 then EQ
    drive(1, 0, 0, alu(32'd10, 32'd10, 1), 1, AL, 4'd4, 1);
    cycle("sub0");
    check("sub0.flags_const", 64'(flags_q), 64'h6);
    drive(1, 0, 0, alu(32'd5, 32'd7, 0), 0, EQ, 4'd5, 1);
    cycle("eq");
    check("eq.exec_const", 64'(exec_cnt), 64'd3);

    // 24 + (-10) without flag update, then NV
    drive(1, 0, 0, alu(32'd24, 32'hFFFF_FFF6, 0), 0, AL, 4'd6, 1);
    cycle("addneg");
    check("addneg.result_const", 64'(out_result), 64'd14);
    drive(1, 0, 0, alu(32'd1, 32'd1, 0), 1, NV, 4'd7, 1);
    cycle("nv");

    // Stall three cycles, then flush+stall
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, alu(32'(i), 32'd3, 0), 1, AL, 4'd8, 1);
      cycle("stall");
    end
    drive(1, 1, 1, alu(32'd9, 32'd9, 1), 1, AL, 4'd9, 1);
    cycle("flushstall");

    // 1 - 10 then GE (squash) then LT (exec)
    drive(1, 0, 0, alu(32'd1, 32'd10, 1), 1, AL, 4'd2, 1);
    cycle("neg");
    check("neg.result_const", 64'(out_result), 64'hFFFF_FFF7);
    check("neg.flags_const", 64'(flags_q), 64'h8);
    drive(1, 0, 0, alu(32'd0, 32'd0, 0), 1, GE, 4'd10, 1);
    cycle("ge");
    drive(1, 0, 0, alu(32'd42, 32'd0, 0), 0, LT, 4'd11, 1);
    cycle("lt");

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
            {$urandom(), 4'($urandom())}, 1'($urandom()), 4'($urandom()), 4'($urandom()),
            1'($urandom()));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
